// File: rtl/alkmuxenc_pkg.sv
// Shared constants, state encoding and helpers for the ALK MUX-field encoder.
// Carry-force checker enabled by defining ALKMUXENC_CHECK_EN.
package alkmuxenc_pkg;

  localparam logic [2:0] SRC_PASS  = 3'd0;
  localparam logic [2:0] SRC_SHIFT = 3'd1;
  localparam logic [2:0] SRC_BSWAP = 3'd2;
  localparam logic [2:0] SRC_SEXT  = 3'd3;
  localparam logic [2:0] SRC_ZXB   = 3'd4;
  localparam logic [2:0] SRC_ZXW   = 3'd5;
  localparam logic [2:0] SRC_LIT   = 3'd6;
  localparam logic [2:0] SRC_ILL   = 3'd7;

  localparam logic [1:0] LSZ_BYTE = 2'b00;
  localparam logic [1:0] LSZ_WORD = 2'b01;
  localparam logic [1:0] LSZ_LONG = 2'b10;
  localparam logic [1:0] LSZ_ILL  = 2'b11;

  localparam logic [3:0] MUX_PASS  = 4'b0000;
  localparam logic [3:0] MUX_SHIFT = 4'b0001;
  localparam logic [3:0] MUX_BSWAP = 4'b0010;
  localparam logic [3:0] MUX_SEXT  = 4'b0011;
  localparam logic [3:0] MUX_ZXB   = 4'b0100;
  localparam logic [3:0] MUX_ZXW   = 4'b1100;
  localparam logic [3:0] MUX_LIT   = 4'b0111;
  localparam logic [3:0] MUX_RSVD  = 4'b1101;
  localparam logic [3:0] MUX_LITL  = 4'b1111;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StIssue = 2'd2
  } state_e;

  function automatic int unsigned lsz_bytes(input logic [1:0] lsz);
    case (lsz)
      LSZ_BYTE: return 1;
      LSZ_WORD: return 2;
      default:  return 4;
    endcase
  endfunction

  // Fields whose ALK path forces carry-out low.
  function automatic logic force_cout0(input logic [3:0] mux, input logic long_l);
    return (mux == MUX_ZXB) || (mux == MUX_ZXW) || (mux == MUX_LIT) ||
           (mux == MUX_RSVD) || (mux == MUX_LITL) || !long_l;
  endfunction

endpackage

// File: rtl/alkmuxenc_lut.sv
// Combinational source-class/literal-size to MUX field encoder with illegal-code detect.
module alkmuxenc_lut
  import alkmuxenc_pkg::*;
(
  input  logic [2:0] i_src,
  input  logic [1:0] i_size,
  output logic [3:0] o_mux,
  output logic       o_lit,
  output logic       o_err
);

  always_comb begin
    o_mux = MUX_PASS;
    o_lit = 1'b0;
    o_err = 1'b0;
    unique case (i_src)
      SRC_PASS:  o_mux = MUX_PASS;
      SRC_SHIFT: o_mux = MUX_SHIFT;
      SRC_BSWAP: o_mux = MUX_BSWAP;
      SRC_SEXT:  o_mux = MUX_SEXT;
      SRC_ZXB:   o_mux = MUX_ZXB;
      SRC_ZXW:   o_mux = MUX_ZXW;
      SRC_LIT: begin
        if (i_size == LSZ_ILL) begin
          o_err = 1'b1;
        end else begin
          o_lit = 1'b1;
          o_mux = (i_size == LSZ_LONG) ? MUX_LITL : MUX_LIT;
        end
      end
      SRC_ILL:   o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alkmuxenc.sv
// ALK MUX-field encoder: accepts source-class micro-ops, fetches literal bytes from the IB,
// issues mux_h/long_lit_l/lit_data_h. Optional carry-force predictor: ALKMUXENC_CHECK_EN.
module alkmuxenc
  import alkmuxenc_pkg::*;
#(
  parameter int unsigned LIT_W = 32,
  parameter int unsigned MAXB  = 4
) (
  input  logic             clk_h,
  input  logic             reset_l,
  input  logic             uop_valid_h,
  input  logic [2:0]       uop_src_h,
  input  logic [1:0]       lit_size_h,
  input  logic             flush_h,
  input  logic             ib_valid_h,
  input  logic [7:0]       ib_byte_h,
  output logic             ib_take_h,
  output logic             busy_h,
  output logic             issue_h,
  output logic [3:0]       mux_h,
  output logic             long_lit_l,
  output logic [LIT_W-1:0] lit_data_h,
  output logic             err_h,
  output logic             force_cout0_l
);

  localparam int unsigned CntW = $clog2(MAXB + 1);

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [1:0]       r_size, w_size_d;
  logic [3:0]       r_mux, w_mux_d;
  logic [LIT_W-1:0] r_lit, w_lit_d;
  logic             r_issue, w_issue_d;
  logic             r_long, w_long_d;
  logic             r_err, w_err_d;
  logic             r_busy;

  logic [2:0] w_lut_src;
  logic [1:0] w_lut_size;
  logic [3:0] w_lut_mux;
  logic       w_lut_lit;
  logic       w_lut_err;

  // While fetching, the encoder is re-pointed at the latched literal size.
  assign w_lut_src  = (r_state == StFetch) ? SRC_LIT : uop_src_h;
  assign w_lut_size = (r_state == StFetch) ? r_size  : lit_size_h;

  alkmuxenc_lut u_lut (
    .i_src  (w_lut_src),
    .i_size (w_lut_size),
    .o_mux  (w_lut_mux),
    .o_lit  (w_lut_lit),
    .o_err  (w_lut_err)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_size_d  = r_size;
    w_mux_d   = r_mux;
    w_lit_d   = r_lit;
    w_issue_d = 1'b0;
    w_long_d  = 1'b1;
    w_err_d   = 1'b0;
    ib_take_h = 1'b0;
    if (flush_h) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (uop_valid_h) begin
            if (w_lut_err) begin
              w_err_d = 1'b1;
            end else if (w_lut_lit) begin
              w_state_d = StFetch;
              w_size_d  = lit_size_h;
              w_cnt_d   = '0;
              w_lit_d   = '0;
            end else begin
              w_state_d = StIssue;
              w_mux_d   = w_lut_mux;
              w_issue_d = 1'b1;
            end
          end
        end
        StFetch: begin
          ib_take_h = ib_valid_h;
          if (ib_valid_h) begin
            for (int b = 0; b < int'(LIT_W / 8); b++) begin
              if (r_cnt == CntW'(b)) w_lit_d[8*b +: 8] = ib_byte_h;
            end
            w_cnt_d = r_cnt + CntW'(1);
            if (w_cnt_d == CntW'(lsz_bytes(r_size))) begin
              w_state_d = StIssue;
              w_cnt_d   = '0;
              w_mux_d   = w_lut_mux;
              w_long_d  = (r_size != LSZ_LONG);
              w_issue_d = 1'b1;
            end
          end
        end
        StIssue: w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_size  <= LSZ_BYTE;
      r_mux   <= MUX_PASS;
      r_lit   <= '0;
      r_issue <= 1'b0;
      r_long  <= 1'b1;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_size  <= w_size_d;
      r_mux   <= w_mux_d;
      r_lit   <= w_lit_d;
      r_issue <= w_issue_d;
      r_long  <= w_long_d;
      r_err   <= w_err_d;
      r_busy  <= (w_state_d != StIdle);
    end
  end

  assign busy_h     = r_busy;
  assign issue_h    = r_issue;
  assign mux_h      = r_mux;
  assign long_lit_l = r_long;
  assign lit_data_h = r_lit;
  assign err_h      = r_err;

`ifdef ALKMUXENC_CHECK_EN
  logic r_force;

  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      r_force <= 1'b1;
    end else begin
      r_force <= ~(w_issue_d & force_cout0(w_mux_d, w_long_d));
    end
  end

  assign force_cout0_l = r_force;
`else
  assign force_cout0_l = 1'b1;
`endif

endmodule

// File: tb/tb_alkmuxenc.sv
// Bench for alkmuxenc: directed vector table, flush/reset sequences and randomized requests
// checked against a request-level reference model.
module tb_alkmuxenc;

  logic        clk_h = 1'b0;
  logic        reset_l;
  logic        uop_valid_h;
  logic [2:0]  uop_src_h;
  logic [1:0]  lit_size_h;
  logic        flush_h;
  logic        ib_valid_h;
  logic [7:0]  ib_byte_h;
  logic        ib_take_h;
  logic        busy_h;
  logic        issue_h;
  logic [3:0]  mux_h;
  logic        long_lit_l;
  logic [31:0] lit_data_h;
  logic        err_h;
  logic        force_cout0_l;

  always #5 clk_h = ~clk_h;

  alkmuxenc dut (
    .clk_h         (clk_h),
    .reset_l       (reset_l),
    .uop_valid_h   (uop_valid_h),
    .uop_src_h     (uop_src_h),
    .lit_size_h    (lit_size_h),
    .flush_h       (flush_h),
    .ib_valid_h    (ib_valid_h),
    .ib_byte_h     (ib_byte_h),
    .ib_take_h     (ib_take_h),
    .busy_h        (busy_h),
    .issue_h       (issue_h),
    .mux_h         (mux_h),
    .long_lit_l    (long_lit_l),
    .lit_data_h    (lit_data_h),
    .err_h         (err_h),
    .force_cout0_l (force_cout0_l)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_lit;
  bit          lit_known;

  typedef struct {
    int          src;
    int          size;
    logic [31:0] data;
    int unsigned stall;
    logic [3:0]  exp_mux;
    logic        exp_long;
    logic [31:0] exp_lit;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  // Reference model: MUX field per source class, literal sizes, error rule.
  function automatic logic [3:0] ref_mux(input int src, input int size);
    logic [3:0] tbl [8];
    tbl = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hC, 4'h7, 4'h0};
    if (src == 6 && size == 2) return 4'hF;
    return tbl[src];
  endfunction

  function automatic bit ref_err(input int src, input int size);
    return (src == 7) || (src == 6 && size == 3);
  endfunction

  function automatic int ref_nbytes(input int size);
    return (size == 0) ? 1 : (size == 1) ? 2 : 4;
  endfunction

  function automatic logic ref_force(input logic [3:0] m, input logic l);
`ifdef ALKMUXENC_CHECK_EN
    return (m inside {4'h4, 4'hC, 4'h7, 4'hD, 4'hF} || !l) ? 1'b0 : 1'b1;
`else
    return (m == m && l == l) ? 1'b1 : 1'b1;
`endif
  endfunction

  // Entered at #1 after a rising edge in an IDLE cycle; leaves in the IDLE cycle after the op.
  task automatic do_req(input int src, input int size, input logic [31:0] data,
                        input int unsigned stall, input logic [3:0] em, input logic el,
                        input logic [31:0] elit, input logic eerr, input string tag);
    int k;
    int cyc;
    int takes;
    chk({tag, " idle busy"}, busy_h, 1'b0);
    uop_valid_h = 1'b1;
    uop_src_h   = 3'(src);
    lit_size_h  = 2'(size);
    ib_valid_h  = 1'b1;
    ib_byte_h   = 8'h5A;
    #3;
    chk({tag, " idle take"}, ib_take_h, 1'b0);
    tick();
    uop_valid_h = 1'b0;
    ib_valid_h  = 1'b0;
    if (eerr) begin
      chk({tag, " err"}, err_h, 1'b1);
      chk({tag, " err issue"}, issue_h, 1'b0);
      chk({tag, " err busy"}, busy_h, 1'b0);
      ib_valid_h = 1'b1;
      #3;
      chk({tag, " err take"}, ib_take_h, 1'b0);
      ib_valid_h = 1'b0;
      tick();
      chk({tag, " err pulse"}, err_h, 1'b0);
      return;
    end
    chk({tag, " no err"}, err_h, 1'b0);
    if (src == 6) begin
      chk({tag, " fetch busy"}, busy_h, 1'b1);
      chk({tag, " fetch issue"}, issue_h, 1'b0);
      k = 0;
      cyc = 0;
      takes = 0;
      while (k < ref_nbytes(size) && cyc < 64) begin
        ib_valid_h = !stall[cyc % 32];
        ib_byte_h  = data[8*k +: 8];
        #3;
        chk({tag, " take"}, ib_take_h, ib_valid_h);
        if (ib_take_h) takes++;
        if (ib_valid_h) k++;
        cyc++;
        tick();
      end
      ib_valid_h = 1'b0;
      chk({tag, " take count"}, takes, ref_nbytes(size));
      if (k < ref_nbytes(size)) begin
        chk({tag, " fetch timeout"}, 1'b1, 1'b0);
        return;
      end
      last_lit  = elit;
      lit_known = 1'b1;
    end
    chk({tag, " issue"}, issue_h, 1'b1);
    chk({tag, " busy"}, busy_h, 1'b1);
    chk({tag, " mux"}, mux_h, em);
    chk({tag, " long"}, long_lit_l, el);
    chk({tag, " force"}, force_cout0_l, ref_force(em, el));
    if (lit_known) chk({tag, " lit"}, lit_data_h, last_lit);
    ib_valid_h = 1'b1;
    #3;
    chk({tag, " issue take"}, ib_take_h, 1'b0);
    ib_valid_h = 1'b0;
    tick();
    chk({tag, " issue pulse"}, issue_h, 1'b0);
    chk({tag, " post busy"}, busy_h, 1'b0);
    chk({tag, " post long"}, long_lit_l, 1'b1);
    chk({tag, " mux hold"}, mux_h, em);
    chk({tag, " post force"}, force_cout0_l, 1'b1);
    if (lit_known) chk({tag, " lit hold"}, lit_data_h, last_lit);
  endtask

  vec_t vecs [11];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int src;
    int size;
    logic [31:0] data;
    logic [31:0] elit;
    logic [3:0]  em;

    vecs[0]  = '{1, 0, 32'h0,        0,   4'h1, 1'b1, 32'h0,        1'b0};
    vecs[1]  = '{6, 2, 32'h12345678, 4,   4'hF, 1'b0, 32'h12345678, 1'b0};
    vecs[2]  = '{6, 0, 32'hDEADBEA5, 0,   4'h7, 1'b1, 32'h000000A5, 1'b0};
    vecs[3]  = '{6, 1, 32'h9977BEEF, 1,   4'h7, 1'b1, 32'h0000BEEF, 1'b0};
    vecs[4]  = '{0, 0, 32'h0,        0,   4'h0, 1'b1, 32'h0,        1'b0};
    vecs[5]  = '{2, 1, 32'h0,        0,   4'h2, 1'b1, 32'h0,        1'b0};
    vecs[6]  = '{3, 3, 32'h0,        0,   4'h3, 1'b1, 32'h0,        1'b0};
    vecs[7]  = '{4, 0, 32'h0,        0,   4'h4, 1'b1, 32'h0,        1'b0};
    vecs[8]  = '{5, 2, 32'h0,        0,   4'hC, 1'b1, 32'h0,        1'b0};
    vecs[9]  = '{7, 0, 32'h0,        0,   4'h0, 1'b1, 32'h0,        1'b1};
    vecs[10] = '{6, 3, 32'h0,        0,   4'h0, 1'b1, 32'h0,        1'b1};

    reset_l = 1'b0;
    uop_valid_h = 1'b0;
    uop_src_h = 3'd0;
    lit_size_h = 2'd0;
    flush_h = 1'b0;
    ib_valid_h = 1'b0;
    ib_byte_h = 8'h00;
    last_lit = 32'h0;
    lit_known = 1'b1;
    #12;
    chk("reset busy", busy_h, 1'b0);
    chk("reset issue", issue_h, 1'b0);
    chk("reset mux", mux_h, 4'h0);
    chk("reset long", long_lit_l, 1'b1);
    chk("reset lit", lit_data_h, 32'h0);
    chk("reset err", err_h, 1'b0);
    chk("reset force", force_cout0_l, 1'b1);
    reset_l = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].src, vecs[i].size, vecs[i].data, vecs[i].stall, vecs[i].exp_mux,
             vecs[i].exp_long, vecs[i].exp_lit, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Flush after the first byte of a word literal; a busy-time request must be ignored.
    uop_valid_h = 1'b1; uop_src_h = 3'd6; lit_size_h = 2'd1;
    tick();
    uop_valid_h = 1'b1; uop_src_h = 3'd7;
    ib_valid_h = 1'b1; ib_byte_h = 8'h11;
    #3;
    chk("flush first take", ib_take_h, 1'b1);
    tick();
    chk("busy ignores req", err_h, 1'b0);
    uop_valid_h = 1'b0;
    flush_h = 1'b1; ib_byte_h = 8'h22;
    #3;
    chk("flush take", ib_take_h, 1'b0);
    tick();
    flush_h = 1'b0;
    chk("flush busy", busy_h, 1'b0);
    chk("flush issue", issue_h, 1'b0);
    #3;
    chk("flush idle take", ib_take_h, 1'b0);
    ib_valid_h = 1'b0;
    lit_known = 1'b0;
    do_req(5, 0, 32'h0, 0, 4'hC, 1'b1, 32'h0, 1'b0, "postflush");

    // Flush beats a simultaneous request.
    uop_valid_h = 1'b1; uop_src_h = 3'd1; flush_h = 1'b1;
    tick();
    uop_valid_h = 1'b0; flush_h = 1'b0;
    chk("flush vs req issue", issue_h, 1'b0);
    chk("flush vs req busy", busy_h, 1'b0);
    tick();
    chk("flush vs req late", issue_h, 1'b0);

    // Asynchronous reset mid-fetch.
    uop_valid_h = 1'b1; uop_src_h = 3'd6; lit_size_h = 2'd2;
    tick();
    uop_valid_h = 1'b0; ib_valid_h = 1'b1; ib_byte_h = 8'hAB;
    tick();
    #2;
    reset_l = 1'b0;
    #1;
    chk("midreset busy", busy_h, 1'b0);
    chk("midreset lit", lit_data_h, 32'h0);
    chk("midreset mux", mux_h, 4'h0);
    ib_valid_h = 1'b0;
    tick();
    reset_l = 1'b1;
    tick();
    last_lit = 32'h0;
    lit_known = 1'b1;
    do_req(6, 2, 32'hCAFEF00D, 32'h2, 4'hF, 1'b0, 32'hCAFEF00D, 1'b0, "postreset");

    // Randomized requests against the reference model.
    for (int n = 0; n < 150; n++) begin
      src  = $urandom_range(0, 7);
      size = $urandom_range(0, 3);
      data = $urandom;
      em   = ref_mux(src, size);
      elit = (src == 6 && !ref_err(src, size)) ?
             32'((64'(data)) % (64'd1 << (8 * ref_nbytes(size)))) : 32'h0;
      do_req(src, size, data, $urandom & $urandom & $urandom, em,
             !(src == 6 && size == 2), elit, ref_err(src, size), $sformatf("rnd%0d", n));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        ib_valid_h = 1'($urandom);
        #3;
        chk("gap take", ib_take_h, 1'b0);
        ib_valid_h = 1'b0;
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
